// File: rtl/ring_endpoint_ctrl_if.sv
// Handshake and router-configuration bundle between the slide unit,
// the ring router and the ring endpoint controller.
interface ring_endpoint_ctrl_if #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 16
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [CntWidth-1:0]  req_len_i;
  logic                 req_dir_i;
  logic [DataWidth-1:0] src_data_i;
  logic                 src_valid_i;
  logic                 src_ready_o;
  logic [DataWidth-1:0] ring_data_o;
  logic                 ring_valid_o;
  logic                 ring_ready_i;
  logic [DataWidth-1:0] ring_data_i;
  logic                 ring_valid_i;
  logic                 ring_ready_o;
  logic [DataWidth-1:0] dst_data_o;
  logic                 dst_valid_o;
  logic                 dst_ready_i;
  logic                 dir_o;
  logic                 bypass_o;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  req_valid_i, req_len_i, req_dir_i,
    input  src_data_i, src_valid_i,
    input  ring_ready_i, ring_data_i, ring_valid_i,
    input  dst_ready_i,
    output req_ready_o, src_ready_o,
    output ring_data_o, ring_valid_o, ring_ready_o,
    output dst_data_o, dst_valid_o,
    output dir_o, bypass_o, busy_o, done_o
  );

  modport master (
    output req_valid_i, req_len_i, req_dir_i,
    output src_data_i, src_valid_i,
    output ring_ready_i, ring_data_i, ring_valid_i,
    output dst_ready_i,
    input  req_ready_o, src_ready_o,
    input  ring_data_o, ring_valid_o, ring_ready_o,
    input  dst_data_o, dst_valid_o,
    input  dir_o, bypass_o, busy_o, done_o
  );
endinterface

// File: rtl/ring_endpoint_ctrl.sv
// Ring endpoint: configures the router, streams len elements out and
// collects len elements back through a 2-entry buffer.
module ring_endpoint_ctrl #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 16
) (
  input logic clk_i,
  input logic rst_i,
  ring_endpoint_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    DONE
  } state_e;

  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  state_e state_q, state_d;

  logic [CntWidth-1:0]  len_q;
  logic [CntWidth-1:0]  tx_cnt_q;
  logic [CntWidth-1:0]  rx_cnt_q;
  logic                 dir_q;
  logic [DataWidth-1:0] mem_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           cnt_q, cnt_d;

  logic accept;
  logic active;
  logic tx_open;
  logic rx_open;
  logic fifo_full;
  logic fifo_empty;
  logic tx_hs;
  logic push;
  logic pop;

  assign active     = (state_q == ACTIVE);
  assign accept     = bus.req_valid_i && (state_q == IDLE);
  assign tx_open    = active && (tx_cnt_q < len_q);
  assign rx_open    = active && (rx_cnt_q < len_q);
  assign fifo_full  = (cnt_q == 2'd2);
  assign fifo_empty = (cnt_q == 2'd0);

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);
  assign bus.dir_o        = dir_q;
  // An empty transfer never leaves bypass, so the DONE pulse keeps it.
  assign bus.bypass_o     = (state_q == IDLE) ||
                            ((state_q == DONE) && (len_q == '0));

  assign bus.ring_data_o  = bus.src_data_i;
  assign bus.ring_valid_o = bus.src_valid_i && tx_open;
  assign bus.src_ready_o  = bus.ring_ready_i && tx_open;
  assign tx_hs            = bus.src_valid_i && bus.ring_ready_i && tx_open;

  // Full blocks the ring even on a pop: no dst_ready to ring_ready path.
  assign bus.ring_ready_o = rx_open && !fifo_full;
  assign push             = bus.ring_valid_i && bus.ring_ready_o;

  assign bus.dst_data_o   = mem_q[rd_ptr_q];
  assign bus.dst_valid_o  = !fifo_empty;
  assign pop              = bus.dst_valid_o && bus.dst_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push && !pop: cnt_d = cnt_q + 2'd1;
      pop && !push: cnt_d = cnt_q - 2'd1;
      default:      cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (bus.req_len_i == '0) ? DONE : SETUP;
        end
      end
      SETUP: state_d = ACTIVE;
      ACTIVE: begin
        if ((tx_cnt_q == len_q) && (rx_cnt_q == len_q) &&
            (cnt_d == 2'd0)) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      dir_q    <= 1'b0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        len_q    <= bus.req_len_i;
        dir_q    <= bus.req_dir_i;
        tx_cnt_q <= '0;
        rx_cnt_q <= '0;
      end
      if (tx_hs) begin
        tx_cnt_q <= tx_cnt_q + CntOne;
      end
      if (push) begin
        rx_cnt_q <= rx_cnt_q + CntOne;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.ring_data_i;
    end
  end

endmodule

// File: tb/tb_ring_endpoint_ctrl.sv
// Bench for ring_endpoint_ctrl: table of directed transfers, random
// transfers against a transfer-level model, reset-abort sequence.
module tb_ring_endpoint_ctrl;

  localparam int DW = 64;
  localparam int CW = 16;
  localparam int MaxCyc = 600;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ring_endpoint_ctrl_if #(.DataWidth(DW), .CntWidth(CW)) bus ();

  ring_endpoint_ctrl #(.DataWidth(DW), .CntWidth(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    int len;
    bit dir;
    int dst_hold;
    int rx_start;
    int exp_done;
  } vec_t;

  int nchk;
  int nerr;
  bit prev_dir;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic bit rnd(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic idle_check(input string tag);
    chk({tag, ".req_ready"}, 64'(bus.req_ready_o), 64'd1);
    chk({tag, ".busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, ".bypass"}, 64'(bus.bypass_o), 64'd1);
    chk({tag, ".done"}, 64'(bus.done_o), 64'd0);
    chk({tag, ".dst_valid"}, 64'(bus.dst_valid_o), 64'd0);
    chk({tag, ".ring_valid_o"}, 64'(bus.ring_valid_o), 64'd0);
    chk({tag, ".src_ready"}, 64'(bus.src_ready_o), 64'd0);
    chk({tag, ".ring_ready_o"}, 64'(bus.ring_ready_o), 64'd0);
    chk({tag, ".dir"}, 64'(bus.dir_o), 64'(prev_dir));
  endtask

  // Transfer-level model: elements sent/received/popped and buffer fill.
  task automatic run_xfer(
    input int len, input bit dir,
    input int p_src, input int p_ring, input int p_dst,
    input int dst_hold, input int rx_start, input int abort_tx,
    input logic [63:0] sbase, input logic [63:0] rbase,
    output int done_c
  );
    int sent, recv, popped, occ, sent_b, recv_b;
    bit hs_tx, hs_rx, hs_dst, exp_done, aborting, act;
    done_c = -1;
    sent = 0; recv = 0; popped = 0; occ = 0;
    hs_tx = 0; hs_rx = 0; aborting = 0;
    @(posedge clk); #1;
    bus.req_valid_i  = 1'b1;
    bus.req_len_i    = CW'(len);
    bus.req_dir_i    = dir;
    bus.src_valid_i  = 1'b0;
    bus.ring_valid_i = 1'b0;
    bus.ring_ready_i = 1'b0;
    bus.dst_ready_i  = 1'b0;
    @(negedge clk);
    idle_check("accept");
    prev_dir = dir;
    exp_done = (len == 0);
    for (int c = 1; c <= MaxCyc; c++) begin
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      if (aborting) begin
        rst = 1'b1;
        bus.src_valid_i  = 1'b0;
        bus.ring_valid_i = 1'b0;
        bus.dst_ready_i  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        prev_dir = 1'b0;
        idle_check("abort");
        done_c = -2;
        return;
      end
      if (!bus.src_valid_i || hs_tx) bus.src_valid_i = rnd(p_src);
      bus.src_data_i = sbase + 64'(sent);
      if (c < rx_start) bus.ring_valid_i = 1'b0;
      else if (!bus.ring_valid_i || hs_rx) bus.ring_valid_i = rnd(p_ring);
      bus.ring_data_i  = rbase + 64'(recv);
      bus.ring_ready_i = rnd(p_ring);
      bus.dst_ready_i  = (c < dst_hold) ? 1'b0 : rnd(p_dst);
      @(negedge clk);
      chk("done", 64'(bus.done_o), 64'(exp_done));
      if (bus.done_o || exp_done) begin
        chk("end.sent", 64'(sent), 64'(len));
        chk("end.recv", 64'(recv), 64'(len));
        chk("end.popped", 64'(popped), 64'(len));
        chk("end.bypass", 64'(bus.bypass_o), 64'(len == 0));
        chk("end.busy", 64'(bus.busy_o), 64'd1);
        done_c = c;
        break;
      end
      act = (c >= 2);
      chk("busy", 64'(bus.busy_o), 64'd1);
      chk("bypass", 64'(bus.bypass_o), 64'd0);
      chk("dir", 64'(bus.dir_o), 64'(dir));
      chk("req_ready", 64'(bus.req_ready_o), 64'd0);
      chk("ring_valid_o", 64'(bus.ring_valid_o),
          64'(act && bus.src_valid_i && sent < len));
      chk("src_ready", 64'(bus.src_ready_o),
          64'(act && bus.ring_ready_i && sent < len));
      chk("ring_ready_o", 64'(bus.ring_ready_o),
          64'(act && occ < 2 && recv < len));
      chk("dst_valid", 64'(bus.dst_valid_o), 64'(occ > 0));
      if (bus.ring_valid_o) chk("ring_data", bus.ring_data_o, sbase + 64'(sent));
      if (occ > 0) chk("dst_data", bus.dst_data_o, rbase + 64'(popped));
      hs_tx  = bus.ring_valid_o && bus.ring_ready_i;
      hs_rx  = bus.ring_valid_i && bus.ring_ready_o;
      hs_dst = bus.dst_valid_o && bus.dst_ready_i;
      sent_b = sent;
      recv_b = recv;
      sent   += int'(hs_tx);
      recv   += int'(hs_rx);
      popped += int'(hs_dst);
      occ    = recv - popped;
      exp_done = (sent_b == len) && (recv_b == len) && (occ == 0);
      if (abort_tx > 0 && sent >= abort_tx && recv >= 2) aborting = 1'b1;
    end
    if (done_c == -1) begin
      nchk++;
      nerr++;
      $display("FAIL timeout: len=%0d no done_o, required within %0d cycles",
               len, MaxCyc);
    end
  endtask

  vec_t vecs [6];
  int   dc;

  initial begin
    nchk = 0;
    nerr = 0;
    prev_dir = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_len_i    = '0;
    bus.req_dir_i    = 1'b0;
    bus.src_data_i   = '0;
    bus.src_valid_i  = 1'b0;
    bus.ring_ready_i = 1'b0;
    bus.ring_data_i  = '0;
    bus.ring_valid_i = 1'b0;
    bus.dst_ready_i  = 1'b0;
    rst = 1'b1;

    vecs[0] = '{len: 4, dir: 1'b0, dst_hold: 0, rx_start: 0, exp_done: 7};
    vecs[1] = '{len: 0, dir: 1'b1, dst_hold: 0, rx_start: 0, exp_done: 1};
    vecs[2] = '{len: 1, dir: 1'b1, dst_hold: 0, rx_start: 0, exp_done: 4};
    vecs[3] = '{len: 3, dir: 1'b0, dst_hold: 8, rx_start: 0, exp_done: 11};
    vecs[4] = '{len: 5, dir: 1'b1, dst_hold: 0, rx_start: 6, exp_done: 12};
    vecs[5] = '{len: 2, dir: 1'b0, dst_hold: 0, rx_start: 0, exp_done: 5};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle_check("reset");

    foreach (vecs[i]) begin
      run_xfer(vecs[i].len, vecs[i].dir, 100, 100, 100,
               vecs[i].dst_hold, vecs[i].rx_start, 0,
               64'hA0, 64'h5000, dc);
      chk($sformatf("latency[%0d]", i), 64'(dc), 64'(vecs[i].exp_done));
    end

    for (int r = 0; r < 25; r++) begin
      run_xfer(int'($urandom_range(10)), 1'($urandom_range(1)),
               int'($urandom_range(30, 100)),
               int'($urandom_range(30, 100)),
               int'($urandom_range(30, 100)),
               int'($urandom_range(4)), int'($urandom_range(5)), 0,
               {$urandom, $urandom}, {$urandom, $urandom}, dc);
    end

    run_xfer(8, 1'b1, 100, 100, 100, 0, 0, 3,
             64'hC0, 64'h7000, dc);
    chk("abort.path", 64'(dc), -64'sd2);
    run_xfer(2, 1'b1, 100, 100, 100, 0, 0, 0,
             64'hD0, 64'h8000, dc);
    chk("after_abort.latency", 64'(dc), 64'd5);

    @(posedge clk); #1;
    @(negedge clk);
    idle_check("final");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
